// File: rtl/sum_carry_packer.sv
// Packs the per-cycle carry/sum bit pair LSB-first into WIDTH-bit words and hands
// each word off through a one-entry registered buffer with popcount, bit count and frame number.
module sum_carry_packer #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             x_carry,
  input  logic             y_sum,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_word,
  output logic [WIDTH-1:0] carry_word,
  output logic [CW-1:0]    bit_count,
  output logic [CW-1:0]    ones_count,
  output logic [7:0]       frame_count
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FULL} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic [CW-1:0]    r_hold_cnt;

  logic             w_fire;
  logic             w_drain;
  logic             w_buf_free;
  logic             w_done;
  logic             w_load_new;
  logic             w_load_held;
  logic [WIDTH-1:0] w_bit;
  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_carry_next;
  logic [CW-1:0]    w_cnt_next;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  assign in_ready     = (r_state != S_FULL);
  assign w_fire       = in_valid & in_ready;
  assign w_drain      = out_valid & out_ready;
  assign w_buf_free   = !out_valid | out_ready;
  assign w_done       = w_fire & ((r_idx == IW'(WIDTH - 1)) | in_last);
  assign w_bit        = WIDTH'(1) << r_idx;
  assign w_sum_next   = r_sum | (y_sum ? w_bit : '0);
  assign w_carry_next = r_carry | (x_carry ? w_bit : '0);
  assign w_cnt_next   = CW'(r_idx) + CW'(1);
  // The held word can only leave FULL through a drain, so the two loads never coincide.
  assign w_load_new   = w_done & w_buf_free;
  assign w_load_held  = (r_state == S_FULL) & w_drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_sum       <= '0;
      r_carry     <= '0;
      r_hold_cnt  <= '0;
      out_valid   <= 1'b0;
      sum_word    <= '0;
      carry_word  <= '0;
      bit_count   <= '0;
      ones_count  <= '0;
      frame_count <= '0;
    end else begin
      if (w_drain) frame_count <= frame_count + 8'd1;

      if (w_load_new) begin
        out_valid  <= 1'b1;
        sum_word   <= w_sum_next;
        carry_word <= w_carry_next;
        bit_count  <= w_cnt_next;
        ones_count <= popcount(w_sum_next);
      end else if (w_load_held) begin
        out_valid  <= 1'b1;
        sum_word   <= r_sum;
        carry_word <= r_carry;
        bit_count  <= r_hold_cnt;
        ones_count <= popcount(r_sum);
      end else if (w_drain) begin
        out_valid  <= 1'b0;
      end

      case (r_state)
        S_FULL: begin
          if (w_drain) begin
            r_state <= S_IDLE;
            r_sum   <= '0;
            r_carry <= '0;
          end
        end
        default: begin
          if (w_fire) begin
            if (w_done) begin
              r_idx <= '0;
              if (w_buf_free) begin
                r_state <= S_IDLE;
                r_sum   <= '0;
                r_carry <= '0;
              end else begin
                // Completed word parks in the collector until the buffer drains.
                r_state    <= S_FULL;
                r_sum      <= w_sum_next;
                r_carry    <= w_carry_next;
                r_hold_cnt <= w_cnt_next;
              end
            end else begin
              r_state <= S_COLLECT;
              r_idx   <= r_idx + IW'(1);
              r_sum   <= w_sum_next;
              r_carry <= w_carry_next;
            end
          end
        end
      endcase
    end
  end

endmodule
